shift_reg_detect: RTL and testbench
===================================

// Module: shift_reg_detect
//
// PURPOSE
//  Parametrised WIDTH-bit register bank with hold, shift-left, shift-right and
//  parallel-load modes, plus a built-in serial pattern matcher. Replaces chains
//  of single-bit flops in the sequence-detector datapath. Shift-left mode feeds
//  the matcher, which detects PATTERN in overlapping or non-overlapping mode.
//
// PARAMETERS
//  WIDTH    6          register width in bits, >= 2
//  PATTERN  6'b010110  WIDTH-bit sequence to detect, MSB = oldest bit
//  OVERLAP  0          1 = overlapping detection, 0 = non-overlapping
//
// PORTS
//  clk      in   1          rising-edge clock
//  reset    in   1          asynchronous, active-high reset
//  en       in   1          cycle enable; 0 = hold everything
//  mode     in   2          00 hold, 01 shift left, 10 shift right, 11 load
//  d_in     in   1          serial data in
//  par_in   in   WIDTH      parallel load data
//  q        out  WIDTH      register contents (registered)
//  s_out    out  1          bit shifted out on last shift (registered)
//  match    out  1          one-cycle pulse: PATTERN completed (registered)
//
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-sequence): q=0, s_out=0, match=0,
//    fill=0. First active edge after reset release is normal operation.
//  - Internal fill counter, $clog2(WIDTH+1) bits, saturates at WIDTH; counts
//    valid history bits in q for matching.
//  - en=0: q, s_out, fill hold; match <= 0.
//  - en=1, mode 00: q, s_out, fill hold; match <= 0.
//  - en=1, mode 01 (shift left): q <= {q[WIDTH-2:0], d_in}; s_out <= q[WIDTH-1];
//    fill <= min(fill+1, WIDTH).
//    match <= ({q[WIDTH-2:0],d_in} == PATTERN) && (fill >= WIDTH-1).
//    On match with OVERLAP=0: fill <= 0 (next match needs WIDTH new bits).
//    On match with OVERLAP=1: fill stays saturated at WIDTH.
//  - en=1, mode 10 (shift right): q <= {d_in, q[WIDTH-1:1]}; s_out <= q[0];
//    fill <= 0 (match history invalidated); match <= 0.
//  - en=1, mode 11 (load): q <= par_in; s_out holds; fill <= WIDTH; match <= 0.
//    Loaded value is history: a following shift-left can match immediately.
//  - Latency: q/s_out update on the edge that samples the command; match is
//    high for exactly the cycle after the completing shift edge.
//  - Fill saturation: shifting beyond WIDTH bits keeps fill at WIDTH; no wrap.
//  - Reset dominates all inputs; en gates mode entirely.
//
// TESTING
//  1 Assert reset mid-stream with q=6'b101101 -> q, s_out, match 0 at once,
//    without a clock edge; next 5 shifts never match (fill < 6).
//  2 Reset, mode=01, shift 0,1,0,1,1,0 -> q=6'b010110, match=1 one cycle after
//    6th edge, 0 the cycle after; s_out=0 throughout.
//  3 OVERLAP=0, shift 0101101 0110 (11 bits) -> match after bit 6 only.
//    OVERLAP=1, same stream -> match after bit 6 and bit 11.
//  4 Load par_in=6'b101011, then shift-left d_in=0 -> q=6'b010110, match=1;
//    s_out=1.
//  5 q=6'b010110 via load, mode=10, d_in=1 -> q=6'b101011, s_out=0, match=0;
//    then shift-left 0 -> q=6'b010110, match=0 (fill cleared by shift right).
//  6 en=0 with mode=01, d_in toggling for 4 cycles -> q, s_out unchanged,
//    match=0; resume en=1 and sequence continues from held state.

Source files
------------

// File: rtl/shift_reg_detect.sv
// WIDTH-bit hold/shift/load register with serial PATTERN matcher fed by shift-left; 1-cycle latency.
// No backpressure: en=0 freezes q, s_out and history; match is a registered single-cycle pulse.
module shift_reg_detect #(
  parameter int               WIDTH   = 6,
  parameter logic [WIDTH-1:0] PATTERN = 6'b010110,
  parameter bit               OVERLAP = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             d_in,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q,
  output logic             s_out,
  output logic             match
);

  localparam int FW = $clog2(WIDTH + 1);

  localparam logic [FW-1:0] FILL_FULL = FW'(WIDTH);
  localparam logic [FW-1:0] FILL_MIN  = FW'(WIDTH - 1);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Number of bits in q that are valid matcher history, saturating at WIDTH.
  logic [FW-1:0]    fill;
  logic [WIDTH-1:0] shl_val;
  logic             hit;

  always_comb begin
    shl_val = {q[WIDTH-2:0], d_in};
    hit     = (shl_val == PATTERN) && (fill >= FILL_MIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q     <= '0;
      s_out <= 1'b0;
      match <= 1'b0;
      fill  <= '0;
    end else begin
      match <= 1'b0;
      if (en) begin
        case (mode)
          MODE_SHL: begin
            q     <= shl_val;
            s_out <= q[WIDTH-1];
            match <= hit;
            // Non-overlapping: a match consumes the whole window.
            if (hit && !OVERLAP)
              fill <= '0;
            else if (fill != FILL_FULL)
              fill <= fill + FW'(1);
          end
          MODE_SHR: begin
            q     <= {d_in, q[WIDTH-1:1]};
            s_out <= q[0];
            fill  <= '0;
          end
          MODE_LOAD: begin
            q    <= par_in;
            fill <= FILL_FULL;
          end
          MODE_HOLD: ;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_detect.sv
// Randomised and directed bench for shift_reg_detect, OVERLAP=0 and OVERLAP=1 instances side by side.
module tb_shift_reg_detect;

  localparam int         W   = 6;
  localparam logic [5:0] PAT = 6'b010110;

  logic         clk = 1'b0;
  logic         reset, en, d_in;
  logic [1:0]   mode;
  logic [W-1:0] par_in;
  logic [W-1:0] q0, q1;
  logic         s0, s1, m0, m1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: k=0 non-overlapping, k=1 overlapping.
  int              mq   [2];
  int              ms   [2];
  int              mm   [2];
  int              hcnt [2];
  longint unsigned hb   [2];

  always #5 clk = ~clk;

  shift_reg_detect #(.WIDTH(W), .PATTERN(PAT), .OVERLAP(1'b0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d_in(d_in),
    .par_in(par_in), .q(q0), .s_out(s0), .match(m0)
  );

  shift_reg_detect #(.WIDTH(W), .PATTERN(PAT), .OVERLAP(1'b1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d_in(d_in),
    .par_in(par_in), .q(q1), .s_out(s1), .match(m1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k] = 0; ms[k] = 0; mm[k] = 0; hcnt[k] = 0; hb[k] = 0;
    end
  endtask

  // History is an unbounded bit string plus a count of bits seen since it was last invalidated.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      mm[k] = 0;
      if (en) begin
        case (mode)
          2'b01: begin
            ms[k]   = (mq[k] >> (W - 1)) & 1;
            mq[k]   = (mq[k] * 2 + int'(d_in)) % (1 << W);
            hb[k]   = (hb[k] << 1) | longint'(d_in);
            hcnt[k] = hcnt[k] + 1;
            if (hcnt[k] >= W && int'(hb[k] % 64) == int'(PAT)) begin
              mm[k] = 1;
              if (k == 0) begin
                hcnt[k] = 0;
                hb[k]   = 0;
              end
            end
          end
          2'b10: begin
            ms[k]   = mq[k] % 2;
            mq[k]   = mq[k] / 2 + int'(d_in) * (1 << (W - 1));
            hcnt[k] = 0;
            hb[k]   = 0;
          end
          2'b11: begin
            mq[k]   = int'(par_in);
            hb[k]   = longint'(par_in);
            hcnt[k] = W;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_q0"}, q0, mq[0]);
    chk({tag, "_s0"}, s0, ms[0]);
    chk({tag, "_m0"}, m0, mm[0]);
    chk({tag, "_q1"}, q1, mq[1]);
    chk({tag, "_s1"}, s1, ms[1]);
    chk({tag, "_m1"}, m1, mm[1]);
  endtask

  task automatic step(input string tag, input logic e, input logic [1:0] md,
                      input logic d, input logic [W-1:0] p);
    en = e; mode = md; d_in = d; par_in = p;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Asynchronous: outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [10:0] stream;
    reset = 1'b1; en = 1'b0; mode = 2'b00; d_in = 1'b0; par_in = '0;
    #1;
    model_reset();
    check_all("por");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Pattern from clean reset, then one idle cycle.
    for (int i = W - 1; i >= 0; i--) step("t2", 1'b1, 2'b01, PAT[i], '0);
    chk("t2_q_exact", q0, 6'b010110);
    chk("t2_match_hi", m0, 1'b1);
    step("t2_idle", 1'b1, 2'b00, 1'b0, '0);
    chk("t2_match_lo", m0, 1'b0);

    // Overlap vs non-overlap on the same stream.
    do_reset("t3_rst");
    stream = 11'b01011010110;
    for (int i = 10; i >= 0; i--) step("t3", 1'b1, 2'b01, stream[i], '0);
    chk("t3_nonovl_last", m0, 1'b0);
    chk("t3_ovl_last", m1, 1'b1);

    // Async reset mid-stream, then a would-be pattern with insufficient history.
    step("t1_load", 1'b1, 2'b11, 1'b0, 6'b101101);
    #2;
    do_reset("t1_rst");
    for (int i = W - 2; i >= 0; i--) step("t1", 1'b1, 2'b01, PAT[i], '0);
    chk("t1_q_is_pat", q0, 6'b010110);
    chk("t1_no_match", m1, 1'b0);

    // Load counts as history.
    step("t4_load", 1'b1, 2'b11, 1'b0, 6'b101011);
    step("t4_shl", 1'b1, 2'b01, 1'b0, '0);
    chk("t4_match", m0, 1'b1);
    chk("t4_sout", s0, 1'b1);

    // Shift right invalidates history.
    step("t5_load", 1'b1, 2'b11, 1'b0, 6'b010110);
    step("t5_shr", 1'b1, 2'b10, 1'b1, '0);
    chk("t5_q_shr", q0, 6'b101011);
    step("t5_shl", 1'b1, 2'b01, 1'b0, '0);
    chk("t5_q_shl", q0, 6'b010110);
    chk("t5_no_match", m1, 1'b0);

    // en gates shifting; resume afterwards.
    do_reset("t6_rst");
    for (int i = W - 1; i >= 3; i--) step("t6_pre", 1'b1, 2'b01, PAT[i], '0);
    for (int i = 0; i < 4; i++) step("t6_hold", 1'b0, 2'b01, i[0], '1);
    for (int i = 2; i >= 0; i--) step("t6_post", 1'b1, 2'b01, PAT[i], '0);
    chk("t6_match", m0, 1'b1);

    // Random traffic: shift-left heavy, with occasional loads of near-patterns and resets.
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [1:0] md;
      logic [W-1:0] p;
      r  = $urandom_range(0, 99);
      md = (r < 60) ? 2'b01 : (r < 70) ? 2'b10 : (r < 82) ? 2'b11 : 2'b00;
      p  = ($urandom_range(0, 1) == 1) ? 6'b101011 : W'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2;
        do_reset("rnd_rst");
      end
      step("rnd", ($urandom_range(0, 9) != 0), md, 1'($urandom), p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
